// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between the memory stage and dmem_responder
// The master side is the requesting pipeline stage; the slave side is the responder.
interface dmem_responder_if #(
  parameter int ADDR_W = 48
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [4:0]        req_type;
  logic [63:0]       req_wdata;
  logic              rsp_valid;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_type, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_type, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-request data-memory responder over a 64-bit single-port RAM
// Handles sizing, sign/zero extension, read-modify-write for partial stores and fault checks.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 48
) (
  input logic               clk,
  input logic               n_reset,
  dmem_responder_if.slave   bus
);
  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t      state, state_nx;
  logic [63:0] mem [DEPTH_WORDS];

  logic [IW-1:0] idx_q;
  logic [2:0]    lane_q;
  logic          store_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [63:0]   wdata_q;
  logic [63:0]   rd_q;
  logic [63:0]   rsp_rdata_q;
  logic          rsp_err_q;

  logic          fire;
  logic          req_err;
  logic [IW-1:0] req_idx;
  logic [2:0]    req_lane;
  logic [2:0]    align_mask;
  logic [63:0]   load_sh;
  logic [63:0]   load_ext;
  logic [63:0]   wsh;
  logic [7:0]    byte_en;
  logic [63:0]   wr_word;

  assign req_idx  = bus.req_addr[3 +: IW];
  assign req_lane = bus.req_addr[2:0];

  always_comb begin
    align_mask = 3'b000;
    case (bus.req_type[1:0])
      2'b00:   align_mask = 3'b000;
      2'b01:   align_mask = 3'b001;
      2'b10:   align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign req_err = bus.req_type[3]
                 || (|(req_lane & align_mask))
                 || ((bus.req_addr >> 3) >= ADDR_W'(DEPTH_WORDS));
  assign fire    = bus.req_valid && (state == IDLE);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (fire) begin
          if (req_err)
            state_nx = RSP;
          else if (bus.req_type[4] && (bus.req_type[1:0] == 2'b11))
            state_nx = WR;
          else
            state_nx = RD;
        end
      end
      RD:      state_nx = store_q ? WR : RSP;
      WR:      state_nx = RSP;
      default: begin
        bus.rsp_valid = 1'b1;
        state_nx      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      idx_q   <= '0;
      lane_q  <= '0;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= '0;
    end else if (fire) begin
      idx_q   <= req_idx;
      lane_q  <= req_lane;
      store_q <= bus.req_type[4];
      uns_q   <= bus.req_type[2];
      size_q  <= bus.req_type[1:0];
      wdata_q <= bus.req_wdata;
    end
  end

  // The RAM is read at the handshake edge; the same word feeds both load extraction and merge.
  always_ff @(posedge clk) begin
    if (fire && !req_err) rd_q <= mem[req_idx];
    if (state == WR)      mem[idx_q] <= wr_word;
  end

  always_comb begin
    load_sh  = rd_q >> {lane_q, 3'b000};
    load_ext = load_sh;
    case (size_q)
      2'b00:   load_ext = uns_q ? {56'd0, load_sh[7:0]}  : {{56{load_sh[7]}},  load_sh[7:0]};
      2'b01:   load_ext = uns_q ? {48'd0, load_sh[15:0]} : {{48{load_sh[15]}}, load_sh[15:0]};
      2'b10:   load_ext = uns_q ? {32'd0, load_sh[31:0]} : {{32{load_sh[31]}}, load_sh[31:0]};
      default: load_ext = load_sh;
    endcase
  end

  always_comb begin
    wsh     = wdata_q << {lane_q, 3'b000};
    byte_en = 8'hFF;
    case (size_q)
      2'b00:   byte_en = 8'h01 << lane_q;
      2'b01:   byte_en = 8'h03 << lane_q;
      2'b10:   byte_en = 8'h0F << lane_q;
      default: byte_en = 8'hFF;
    endcase
    wr_word = rd_q;
    for (int i = 0; i < 8; i++) begin
      if (byte_en[i]) wr_word[8*i +: 8] = wsh[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (fire && req_err) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b1;
    end else if (state == RD && !store_q) begin
      rsp_rdata_q <= load_ext;
      rsp_err_q   <= 1'b0;
    end else if (state == WR) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end
  end

  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
// Reference model is a flat little-endian byte array driven by the access rules.
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam int AW    = 48;

  localparam logic [4:0] T_LB  = 5'b00000;
  localparam logic [4:0] T_LH  = 5'b00001;
  localparam logic [4:0] T_LW  = 5'b00010;
  localparam logic [4:0] T_LD  = 5'b00011;
  localparam logic [4:0] T_LBU = 5'b00100;
  localparam logic [4:0] T_LWU = 5'b00110;
  localparam logic [4:0] T_SB  = 5'b10000;
  localparam logic [4:0] T_SH  = 5'b10001;
  localparam logic [4:0] T_SW  = 5'b10010;
  localparam logic [4:0] T_SD  = 5'b10011;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(AW)) bus();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus.slave)
  );

  logic [7:0] mb [0:8*DEPTH-1];
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [AW-1:0] a, input logic [4:0] t, input logic [63:0] d,
                       output logic [63:0] er, output logic ee, output int el);
    int n;
    int base;
    logic [63:0] v;
    n  = 1 << t[1:0];
    ee = t[3] || ((a % n) != 0) || ((a / 8) >= DEPTH);
    er = '0;
    el = 1;
    if (!ee) begin
      base = int'(a);
      if (t[4]) begin
        for (int i = 0; i < n; i++) mb[base+i] = d[8*i +: 8];
        el = (n == 8) ? 2 : 3;
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[base+i];
        if (n < 8 && !t[2] && v[8*n-1]) v = v | (~64'd0 << (8*n));
        er = v;
        el = 2;
      end
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that follows the response.
  task automatic xact(input logic [AW-1:0] a, input logic [4:0] t, input logic [63:0] d,
                      input bit hold, output logic [63:0] got);
    logic [63:0] er;
    logic        ee;
    int          el;
    int          lat;
    int          w;
    bus.req_addr  = a;
    bus.req_type  = t;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check($sformatf("handshake_timeout a=%h", a), 64'(w < 20), 64'd1);
    @(posedge clk); #1;
    model(a, t, d, er, ee, el);
    if (!hold) bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 8) begin
      check($sformatf("busy_ready a=%h t=%b", a, t), 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency a=%h t=%b", a, t), 64'(lat), 64'(el));
    check($sformatf("rsp_ready a=%h t=%b", a, t), 64'(bus.req_ready), 64'd0);
    check($sformatf("rdata a=%h t=%b", a, t), bus.rsp_rdata, er);
    check($sformatf("err a=%h t=%b", a, t), 64'(bus.rsp_err), 64'(ee));
    got = bus.rsp_rdata;
    @(posedge clk); #1;
    check($sformatf("pulse a=%h t=%b", a, t), 64'(bus.rsp_valid), 64'd0);
    check($sformatf("ready_back a=%h t=%b", a, t), 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0]   got;
    logic [4:0]    t;
    logic [AW-1:0] a;
    int            word;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_type  = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.req_ready), 64'd1);
    check("reset_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rdata", bus.rsp_rdata, 64'd0);
    check("reset_err",   64'(bus.rsp_err), 64'd0);
    n_reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++)
      xact(AW'(i * 8), T_SD, {$urandom, $urandom}, 1'b0, got);

    xact(48'h10, T_SD, 64'h1122334455667788, 1'b0, got);
    xact(48'h10, T_LD, 64'd0, 1'b0, got);
    check("ld_10", got, 64'h1122334455667788);
    xact(48'h13, T_SB, 64'hF0, 1'b0, got);
    xact(48'h13, T_LB, 64'd0, 1'b0, got);
    check("lb_13", got, 64'hFFFFFFFFFFFFFFF0);
    xact(48'h13, T_LBU, 64'd0, 1'b0, got);
    check("lbu_13", got, 64'h00000000000000F0);
    xact(48'h10, T_LD, 64'd0, 1'b0, got);
    check("ld_10_merged", got, 64'h11223344F0667788);

    xact(48'h20, T_SD, 64'd0, 1'b0, got);
    xact(48'h24, T_SW, 64'h80000001, 1'b0, got);
    xact(48'h24, T_LW, 64'd0, 1'b0, got);
    check("lw_24", got, 64'hFFFFFFFF80000001);
    xact(48'h24, T_LWU, 64'd0, 1'b0, got);
    check("lwu_24", got, 64'h0000000080000001);
    xact(48'h20, T_LD, 64'd0, 1'b0, got);
    check("ld_20", got, 64'h8000000100000000);

    xact(48'h21, T_LH, 64'd0, 1'b0, got);
    xact(AW'(8 * DEPTH), T_SD, 64'hDEADBEEFDEADBEEF, 1'b0, got);
    xact(48'h20, 5'b11011, 64'hCAFECAFECAFECAFE, 1'b0, got);
    xact(48'h20, T_LD, 64'd0, 1'b0, got);
    check("ld_20_after_errs", got, 64'h8000000100000000);
    xact(48'h0, T_LD, 64'd0, 1'b0, got);

    // Requester holds req_valid high across back-to-back mixed traffic.
    for (int i = 0; i < 16; i++) begin
      t    = (i % 2 == 0) ? {1'b1, 2'b00, 2'($urandom)} : {1'b0, 1'b0, 1'($urandom), 2'($urandom)};
      word = $urandom_range(0, DEPTH - 1);
      a    = AW'(word * 8 + ((int'($urandom_range(0, 7)) >> t[1:0]) << t[1:0]));
      xact(a, t, {$urandom, $urandom}, 1'b1, got);
    end
    bus.req_valid = 1'b0;

    xact(48'h30, T_SD, 64'hAAAAAAAAAAAAAAAA, 1'b0, got);
    bus.req_addr  = 48'h30;
    bus.req_type  = T_SH;
    bus.req_wdata = 64'h5555;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("wr_phase_ready", 64'(bus.req_ready), 64'd0);
    n_reset = 1'b0;
    #1;
    check("rst_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    check("rst_valid_hold", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 64'(bus.req_ready), 64'd1);
    check("post_rst_valid", 64'(bus.rsp_valid), 64'd0);
    xact(48'h30, T_LD, 64'd0, 1'b0, got);
    check("ld_30_abandoned", got, 64'hAAAAAAAAAAAAAAAA);

    for (int i = 0; i < 150; i++) begin
      t = 5'($urandom);
      if ($urandom_range(0, 9) != 0) t[3] = 1'b0;
      word = $urandom_range(0, DEPTH + 3);
      a    = AW'(word * 8 + int'($urandom_range(0, 7)));
      xact(a, t, {$urandom, $urandom}, 1'($urandom), got);
    end
    bus.req_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
